// File: rtl/axi_pkg.sv
// Shared AXI encodings and the burst-master state type used by the initiator
// and by the byte-lane SRAM slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam int BOUNDARY_SHIFT = 12;
  localparam int BOUNDARY_4K    = 1 << BOUNDARY_SHIFT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } mst_state_e;

endpackage

// File: rtl/axi_4k_check.sv
// Combinational 4 KB boundary checker: flags a burst whose last byte lands in
// a different 4 KB page than its first byte.
module axi_4k_check
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int SIZE_WIDTH = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  crosses
);

  localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH + 1;
  localparam logic [SUM_W-1:0] ONE = SUM_W'(1);
  // Page-number bits only: everything below the page offset and above the
  // address width is ignored in the comparison.
  localparam logic [SUM_W-1:0] PAGE_MASK =
    ((ONE << ADDR_WIDTH) - ONE) & ~((ONE << BOUNDARY_SHIFT) - ONE);

  logic [SUM_W-1:0] beats;
  logic [SUM_W-1:0] bytes;
  logic [SUM_W-1:0] start_addr;
  logic [SUM_W-1:0] end_addr;

  always_comb begin
    beats      = SUM_W'(len) + ONE;
    bytes      = beats << size;
    start_addr = SUM_W'(addr);
    end_addr   = start_addr + bytes - ONE;
    crosses    = |((start_addr ^ end_addr) & PAGE_MASK);
  end

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 initiator: one command becomes one write or read
// burst with byte-wide beats streamed through valid/ready ports.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int SIZE_WIDTH = 3,
  parameter int BEAT_WIDTH = 8,
  parameter int RESP_WIDTH = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [SIZE_WIDTH-1:0] cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [BEAT_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [BEAT_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic [RESP_WIDTH-1:0] done_resp,
  output logic                  done_err,
  output logic [ID_WIDTH-1:0]   AWID,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [LEN_WIDTH-1:0]  AWLEN,
  output logic [SIZE_WIDTH-1:0] AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [BEAT_WIDTH-1:0] WDATA,
  output logic                  WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [ID_WIDTH-1:0]   BID,
  input  logic [RESP_WIDTH-1:0] BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ID_WIDTH-1:0]   ARID,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [LEN_WIDTH-1:0]  ARLEN,
  output logic [SIZE_WIDTH-1:0] ARSIZE,
  output logic [1:0]            ARBURST,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [ID_WIDTH-1:0]   RID,
  input  logic [BEAT_WIDTH-1:0] RDATA,
  input  logic [RESP_WIDTH-1:0] RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  mst_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [1:0]            burst_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [RESP_WIDTH-1:0] resp_q;
  logic                  err_q;
  logic                  crosses;
  logic                  in_w, in_r, last_beat, w_hs, r_hs, r_err;
  logic [RESP_WIDTH-1:0] r_worst;

  function automatic logic [RESP_WIDTH-1:0] worst_resp(
    input logic [RESP_WIDTH-1:0] a,
    input logic [RESP_WIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  axi_4k_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .SIZE_WIDTH (SIZE_WIDTH)
  ) u_4k_check (
    .addr    (cmd_addr),
    .len     (cmd_len),
    .size    (cmd_size),
    .crosses (crosses)
  );

  assign in_w      = (state_q == ST_W);
  assign in_r      = (state_q == ST_R);
  assign last_beat = (beat_cnt == len_q);
  assign w_hs      = WVALID && WREADY;
  assign r_hs      = RVALID && RREADY;
  assign r_worst   = worst_resp(resp_q, RRESP);
  // The beat count, not RLAST, ends the burst; a misplaced RLAST is only flagged.
  assign r_err     = (RID != id_q) || (RLAST != last_beat);

  // cmd_ready is held low while reset is asserted so every output reads 0.
  assign cmd_ready = ARESETn && (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);

  assign AWVALID = (state_q == ST_AW);
  assign AWID    = id_q;
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = size_q;
  assign AWBURST = burst_q;
  assign ARVALID = (state_q == ST_AR);
  assign ARID    = id_q;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = size_q;
  assign ARBURST = burst_q;

  assign WVALID   = in_w && wr_valid;
  assign wr_ready = in_w && WREADY;
  assign WDATA    = in_w ? wr_data : '0;
  assign WSTRB    = in_w;
  assign WLAST    = in_w && last_beat;
  assign BREADY   = (state_q == ST_B);

  assign rd_valid = in_r && RVALID;
  assign RREADY   = in_r && rd_ready;
  assign rd_data  = in_r ? RDATA : '0;
  assign rd_last  = in_r && last_beat;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = crosses ? ST_DONE : (cmd_write ? ST_AW : ST_AR);
      ST_AW:   if (AWREADY) state_d = ST_W;
      ST_W:    if (w_hs && last_beat) state_d = ST_B;
      ST_B:    if (BVALID) state_d = ST_DONE;
      ST_AR:   if (ARREADY) state_d = ST_R;
      ST_R:    if (r_hs && last_beat) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_cnt  <= '0;
      resp_q    <= '0;
      err_q     <= 1'b0;
      done_resp <= '0;
      done_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          id_q     <= cmd_id;
          addr_q   <= cmd_addr;
          len_q    <= cmd_len;
          size_q   <= cmd_size;
          burst_q  <= cmd_burst;
          beat_cnt <= '0;
          resp_q   <= RESP_WIDTH'(RESP_OKAY);
          err_q    <= 1'b0;
          if (crosses) begin
            done_resp <= RESP_WIDTH'(RESP_SLVERR);
            done_err  <= 1'b1;
          end
        end
        ST_W: if (w_hs) beat_cnt <= beat_cnt + LEN_WIDTH'(1);
        ST_B: if (BVALID) begin
          done_resp <= BRESP;
          done_err  <= (BID != id_q);
        end
        ST_R: if (r_hs) begin
          beat_cnt <= beat_cnt + LEN_WIDTH'(1);
          if (last_beat) begin
            done_resp <= r_worst;
            done_err  <= err_q || r_err;
          end else begin
            resp_q <= r_worst;
            err_q  <= err_q || r_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Single-outstanding AXI4 initiator that turns a simple command/stream interface into AXI write and read bursts.
- Serves as the counterpart to the byte-lane AXI SRAM slave: testbench stimulus and on-chip engines use it to drive that slave.
- Data path is one byte per beat. Write data enters on a valid/ready stream, read data leaves on a valid/ready stream.
- One completion pulse per command.

Parameters:
- ID_WIDTH, 3, width of AWID/ARID/BID/RID and cmd_id
- ADDR_WIDTH, 32, address width
- LEN_WIDTH, 8, AxLEN width (beats = len+1)
- SIZE_WIDTH, 3, AxSIZE width
- BEAT_WIDTH, 8, data bits per beat
- RESP_WIDTH, 2, xRESP width

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_id  in  ID_WIDTH  transaction ID
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  LEN_WIDTH  beats-1
- cmd_size  in  SIZE_WIDTH  log2 bytes per beat
- cmd_burst  in  2  FIXED=0, INCR=1, WRAP=2
- wr_valid/wr_ready  in/out  1  write-data stream handshake
- wr_data  in  BEAT_WIDTH  write beat
- rd_valid/rd_ready  out/in  1  read-data stream handshake
- rd_data  out  BEAT_WIDTH  read beat
- rd_last  out  1  last read beat
- done  out  1  one-cycle completion pulse
- done_resp  out  RESP_WIDTH  final response
- done_err  out  1  protocol/boundary error
- AWID, AWADDR, AWLEN, AWSIZE, AWBURST  out  per params  write address
- AWVALID out, AWREADY in
- WDATA out BEAT_WIDTH; WSTRB out 1; WLAST out 1; WVALID out; WREADY in
- BID in ID_WIDTH; BRESP in 2; BVALID in; BREADY out
- ARID, ARADDR, ARLEN, ARSIZE, ARBURST out; ARVALID out; ARREADY in
- RID in; RDATA in; RRESP in; RLAST in; RVALID in; RREADY out
- Reset ARESETn, asynchronous, active-low; clock ACLK.

Behaviour:
- Reset: every output 0; state IDLE.
- States: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready=1, decoded from state.
  - On cmd_valid, register the command.
  - Boundary check uses ADDR_WIDTH+LEN_WIDTH+1 bit arithmetic: end = addr + ((len+1) << size) - 1. If addr[ADDR_WIDTH-1:12] != end[ADDR_WIDTH-1:12] (4 KB crossing), go to DONE with done_err=1 and done_resp=SLVERR, with no AXI traffic.
  - Otherwise go to AW (write) or AR (read).
- AW / AR:
  - AxVALID=1 with registered fields from the cycle after acceptance.
  - AxVALID is held stable until AxREADY; on the handshake go to W / R.
  - Address and data are never overlapped.
- W:
  - Combinational pass-through: WVALID=wr_valid, wr_ready=WREADY, WDATA=wr_data, WSTRB=1.
  - WLAST=1 when beat_cnt==len.
  - Each WVALID&WREADY increments beat_cnt. The last beat goes to B.
- B:
  - BREADY=1. On BVALID, capture BRESP.
  - Set done_err if BID != cmd_id. Go to DONE.
- R:
  - Pass-through: rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA, rd_last=(beat_cnt==len).
  - On each beat, keep the worst RRESP (numerically max) and set done_err if RID != cmd_id.
  - If RLAST != (beat_cnt==len), set done_err.
  - After beat len, go to DONE. An early RLAST does not end the burst: the count governs.
- DONE: done=1 for exactly one cycle with done_resp/done_err valid. cmd_ready=0. Next state IDLE; a new command can be accepted the following cycle.
- beat_cnt is LEN_WIDTH bits and clears on command accept. len=255 gives 256 beats with no overflow before the compare.
- AxVALID/WVALID/RREADY/BREADY are 0 in every state not listed above.
- Reset mid-burst: all outputs go to 0 immediately (asynchronous). Any in-flight slave transaction is abandoned; the system resets the slave together with the master.
- done_resp/done_err hold their value until the next DONE.

Decomposition:
- Shared package axi_pkg:
  - Burst encodings FIXED/INCR/WRAP.
  - Response encodings OKAY/EXOKAY/SLVERR/DECERR.
  - 4 KB boundary constant.
  - Master state enum.
- One natural sub-module, axi_4k_check: combinational boundary checker (addr, len, size -> cross). It is reused by the slave for its own range check.

Test Plan:
- Write INCR, addr 0x010, len 3, size 0, data A1..A4, slave ready always high:
  - AWVALID one cycle after accept.
  - Four W beats with WLAST only on beat 4.
  - done with resp OKAY, done_err 0.
- Read INCR, addr 0x010, len 3, with rd_ready toggling 1/0:
  - rd_data A1..A4 in order.
  - RREADY mirrors rd_ready.
  - rd_last on beat 4.
  - done once.
- Command addr 0xFFE, len 3, size 0 (crosses 4 KB):
  - No AWVALID/ARVALID.
  - done the cycle after DONE entry, with done_resp SLVERR and done_err 1.
- Slave holds AWREADY low for 5 cycles:
  - AWVALID and AW fields stable throughout.
  - W starts only after the handshake.
- Read where the slave asserts RLAST on beat 2 of len 3:
  - All 4 beats are still accepted.
  - done_err 1.
- ARESETn low during the W state at beat 2:
  - All valids drop to 0 asynchronously.
  - After release, cmd_ready=1 and a new write of len 0 completes with OKAY.
